multdiv_ctrl: RTL
=================

Name: multdiv_ctrl

Overview:
Sequencer for the multiply/divide unit in the 5-stage CPU.
- Captures a mult/div instruction leaving DX and issues a one-cycle start pulse with latched operands.
- Stalls the front of the pipeline while the unit is running.
- Arbitrates the unit's register-file writeback against the normal MW writeback, and reports multdiv exceptions through rstatus.

Parameters:
TIMEOUT_CYCLES, 64, BUSY cycles allowed before abandoning the operation
CNT_W, 7, width of the busy-cycle counter (must hold TIMEOUT_CYCLES)
RSTATUS_REG, 30, register written on an exception
EXC_MULT, 4, rstatus code for mult overflow
EXC_DIV, 5, rstatus code for divide by zero

Ports:
clk  in  1  system clock; one clock; reset is synchronous and active-low
reset  in  1  synchronous active-low reset, sampled on posedge clk
dx_mult  in  1  DX holds a mult
dx_div  in  1  DX holds a div
dx_a  in  32  operand A from DX
dx_b  in  32  operand B from DX
dx_rd  in  5  destination register of the DX instruction
md_ready  in  1  multdiv result valid, single-cycle pulse
md_result  in  32  multdiv result
md_exception  in  1  multdiv exception, qualified by md_ready
mw_wb_en  in  1  MW stage is writing the register file this cycle
ctrl_mult  out  1  one-cycle mult start pulse
ctrl_div  out  1  one-cycle div start pulse
md_a  out  32  latched operand A
md_b  out  32  latched operand B
dx_nop  out  1  capture pulse; pipeline injects a nop into XM
stall  out  1  freeze PC, FD and DX
busy  out  1  operation in flight
wb_en  out  1  multdiv register-file write strobe
wb_rd  out  5  write register
wb_data  out  32  write data
timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset: reset==0 at posedge → state IDLE, counter 0, all registered outputs and latches 0, timeout_err cleared.
- States: IDLE, START, BUSY, WB. stall = busy = (state != IDLE).
- IDLE:
  - If dx_mult|dx_div, latch a, b, rd and op type, and go to START.
  - dx_nop = 1 combinationally in that cycle; no stall in the capture cycle.
  - If both dx_mult and dx_div are high (illegal), treat it as mult.
- START:
  - ctrl_mult or ctrl_div = 1 for exactly this cycle.
  - md_a/md_b are valid from this cycle until the return to IDLE.
  - Counter cleared; next state BUSY.
  - md_ready in START is ignored.
- BUSY:
  - Counter increments each cycle.
  - On md_ready: latch md_result and md_exception, go to WB.
  - If the counter reaches TIMEOUT_CYCLES-1 without md_ready: set timeout_err, go to IDLE, no writeback.
  - If md_ready arrives in the same cycle as the timeout, md_ready wins.
- WB:
  - wb_en = ~mw_wb_en (combinational). The MW writeback always has priority; WB holds, with stall high, until granted.
  - Next state IDLE after the cycle in which wb_en=1.
  - On exception: wb_rd = RSTATUS_REG, wb_data = EXC_MULT or EXC_DIV zero-extended.
  - Otherwise: wb_rd = latched rd, wb_data = latched result.
  - If there is no exception and rd==0: wb_en stays 0 and the block returns to IDLE after one WB cycle.
- wb_rd/wb_data are driven only while in WB and are 0 elsewhere.
- dx_mult/dx_div are ignored outside IDLE; the front end is frozen.
- Reset mid-operation aborts everything. An md_ready arriving after the reset is ignored in IDLE.
- Latency: from the capture edge, ctrl_* fires at +1. Best-case writeback happens 1 cycle after md_ready.

Decomposition:
- Package multdiv_ctrl_pkg holds:
  - the state encoding (IDLE/START/BUSY/WB, 2 bits)
  - RSTATUS_REG, EXC_MULT, EXC_DIV
- Sub-module multdiv_timeout_counter: clear, enable and terminal-count output, parameterised by CNT_W and TIMEOUT_CYCLES.

Test Plan:
- Mult: dx_mult, a=7, b=6, rd=3; md_ready 16 cycles after ctrl_mult with result 42 → dx_nop at capture, single ctrl_mult pulse, md_a=7/md_b=6, stall high from START through the WB cycle, one wb_en with wb_rd=3, wb_data=42.
- Div by zero: dx_div, b=0, rd=9; md_ready with md_exception=1 → wb_rd=30, wb_data=5, no write to r9.
- Writeback conflict: mw_wb_en high for 3 cycles when WB is entered → wb_en delayed exactly 3 cycles, stall held, data unchanged.
- rd=0: mult with rd=0 and no exception → wb_en never asserted, return to IDLE one cycle after WB entry.
- Timeout: no md_ready → timeout_err=1 after TIMEOUT_CYCLES BUSY cycles, state IDLE, stall drops, timeout_err stays 1 until reset.
- Reset mid-BUSY: reset=0 for one edge → all outputs 0 next cycle; a later md_ready produces no wb_en.

Source files
------------

// File: rtl/multdiv_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package multdiv_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StBusy  = 2'd2,
      StWb    = 2'd3
   } state_e;

   localparam logic [4:0]  RSTATUS_REG = 5'd30;
   localparam logic [31:0] EXC_MULT    = 32'd4;
   localparam logic [31:0] EXC_DIV     = 32'd5;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Handshake between the sequencer (master) and the multdiv unit (slave).
interface multdiv_ctrl_if;

   logic        ctrl_mult;
   logic        ctrl_div;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        md_ready;
   logic [31:0] md_result;
   logic        md_exception;

   modport master (
      output ctrl_mult, ctrl_div, md_a, md_b,
      input  md_ready, md_result, md_exception
   );

   modport slave (
      input  ctrl_mult, ctrl_div, md_a, md_b,
      output md_ready, md_result, md_exception
   );

endinterface

// File: rtl/multdiv_timeout_counter.sv
// Busy-cycle counter; tc flags the last cycle allowed before abandoning the op.
module multdiv_timeout_counter #(
   parameter int unsigned CNT_W          = 7,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign tc = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Captures mult/div from DX, sequences the multdiv unit, stalls the front end
// and arbitrates the unit's writeback against the MW stage.
module multdiv_ctrl
   import multdiv_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 dx_mult,
   input  logic                 dx_div,
   input  logic [31:0]          dx_a,
   input  logic [31:0]          dx_b,
   input  logic [4:0]           dx_rd,
   input  logic                 mw_wb_en,
   multdiv_ctrl_if.master       md,
   output logic                 dx_nop,
   output logic                 stall,
   output logic                 busy,
   output logic                 wb_en,
   output logic [4:0]           wb_rd,
   output logic [31:0]          wb_data,
   output logic                 timeout_err
);

   state_e state_q, state_d;

   logic [31:0] a_q, b_q, result_q;
   logic [4:0]  rd_q;
   logic        div_q, exc_q, timeout_err_q;
   logic        capture, md_done, tc, timeout_hit, wb_req;

   assign capture     = (state_q == StIdle) && (dx_mult || dx_div);
   // md_ready only counts while BUSY; a pulse during START or IDLE is dropped.
   assign md_done     = (state_q == StBusy) && md.md_ready;
   assign timeout_hit = (state_q == StBusy) && tc && !md.md_ready;
   // A clean result targeting r0 needs no write; exceptions always go to rstatus.
   assign wb_req      = exc_q || (rd_q != 5'd0);

   multdiv_timeout_counter #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_counter (
      .clk   (clk),
      .reset (reset),
      .clear (state_q == StStart),
      .en    (state_q == StBusy),
      .tc    (tc)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (capture) state_d = StStart;
         StStart: state_d = StBusy;
         StBusy: begin
            if (md_done) begin
               state_d = StWb;
            end else if (timeout_hit) begin
               state_d = StIdle;
            end
         end
         StWb: begin
            if (!wb_req || !mw_wb_en) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      dx_nop       = capture;
      busy         = (state_q != StIdle);
      stall        = busy;
      md.ctrl_mult = (state_q == StStart) && !div_q;
      md.ctrl_div  = (state_q == StStart) && div_q;
      md.md_a      = a_q;
      md.md_b      = b_q;
      wb_en        = 1'b0;
      wb_rd        = 5'd0;
      wb_data      = 32'd0;
      timeout_err  = timeout_err_q;
      if (state_q == StWb) begin
         wb_en = wb_req && !mw_wb_en;
         if (exc_q) begin
            wb_rd   = RSTATUS_REG;
            wb_data = div_q ? EXC_DIV : EXC_MULT;
         end else begin
            wb_rd   = rd_q;
            wb_data = result_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_q           <= 32'd0;
         b_q           <= 32'd0;
         rd_q          <= 5'd0;
         div_q         <= 1'b0;
         result_q      <= 32'd0;
         exc_q         <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         if (capture) begin
            a_q   <= dx_a;
            b_q   <= dx_b;
            rd_q  <= dx_rd;
            // Both strobes high is illegal; mult takes precedence.
            div_q <= dx_div && !dx_mult;
         end
         if (md_done) begin
            result_q <= md.md_result;
            exc_q    <= md.md_exception;
         end
         if (timeout_hit) timeout_err_q <= 1'b1;
      end
   end

endmodule
